// File: rtl/cla_operand_stage_if.sv
// Operand-in / result-out handshake bundle for cla_operand_stage.
// master = upstream/downstream environment, slave = the stage itself.
interface cla_operand_stage_if #(
    parameter int NBIT = 7
);
    logic            in_valid;
    logic            in_ready;
    logic [NBIT-1:0] in_a;
    logic [NBIT-1:0] in_b;
    logic            out_valid;
    logic            out_ready;
    logic [NBIT-1:0] out_s;

    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_s
    );

    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_s
    );
endinterface

// File: rtl/cla_operand_stage.sv
// Operand FIFO feeding a combinational CLA adder, with a registered, flow-controlled sum output.
// Optional self-check of the adder (err / err_count ports) when CLA_OPERAND_STAGE_CHECK_EN is defined.
module cla_operand_stage #(
    parameter int NBIT  = 7,
    parameter int DEPTH = 4,
    parameter int CNTW  = 3
) (
    input  logic               clk,
    input  logic               rst,
    cla_operand_stage_if.slave bus,
    output logic [NBIT-1:0]    add_a,
    output logic [NBIT-1:0]    add_b,
    input  logic [NBIT-1:0]    add_s,
    output logic [CNTW-1:0]    occupancy
`ifdef CLA_OPERAND_STAGE_CHECK_EN
    ,
    output logic               err,
    output logic [7:0]         err_count
`endif
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [NBIT-1:0] mem_a [DEPTH];
    logic [NBIT-1:0] mem_b [DEPTH];
    logic [PW-1:0]   wr_ptr_p0;
    logic [PW-1:0]   rd_ptr_p0;
    logic [CNTW-1:0] cnt_p0;
    logic [NBIT-1:0] s_p1;
    logic            vld_p1;
    logic            empty;
    logic            full;
    logic            push;
    logic            pop;

    // DEPTH is a power of two, so natural pointer overflow is the modulo-DEPTH wrap.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return p + PW'(1);
    endfunction

    assign empty = (cnt_p0 == '0);
    assign full  = (cnt_p0 == CNTW'(DEPTH));
    assign push  = bus.in_valid && !full;
    assign pop   = !empty && (!vld_p1 || bus.out_ready);

    assign bus.in_ready  = !full;
    assign bus.out_valid = vld_p1;
    assign bus.out_s     = s_p1;
    assign occupancy     = cnt_p0;

    // Stage p0: operand FIFO; the adder sees only stored data, never in_a/in_b directly.
    assign add_a = empty ? '0 : mem_a[rd_ptr_p0];
    assign add_b = empty ? '0 : mem_b[rd_ptr_p0];

    always_ff @(posedge clk) begin
        if (push) begin
            mem_a[wr_ptr_p0] <= bus.in_a;
            mem_b[wr_ptr_p0] <= bus.in_b;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_p0 <= '0;
            rd_ptr_p0 <= '0;
            cnt_p0    <= '0;
        end else begin
            if (push) begin
                wr_ptr_p0 <= ptr_inc(wr_ptr_p0);
            end
            if (pop) begin
                rd_ptr_p0 <= ptr_inc(rd_ptr_p0);
            end
            if (push && !pop) begin
                cnt_p0 <= cnt_p0 + CNTW'(1);
            end else if (pop && !push) begin
                cnt_p0 <= cnt_p0 - CNTW'(1);
            end
        end
    end

    // Stage p1: registered sum; held stable while the consumer stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            s_p1   <= '0;
            vld_p1 <= 1'b0;
        end else if (pop) begin
            s_p1   <= add_s;
            vld_p1 <= 1'b1;
        end else if (vld_p1 && bus.out_ready) begin
            vld_p1 <= 1'b0;
        end
    end

`ifdef CLA_OPERAND_STAGE_CHECK_EN
    function automatic logic [NBIT-1:0] ref_sum(input logic [NBIT-1:0] a, input logic [NBIT-1:0] b);
        return a + b;
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] c);
        return (c == 8'hFF) ? c : c + 8'd1;
    endfunction

    logic mismatch;
    assign mismatch = pop && (add_s != ref_sum(add_a, add_b));

    always_ff @(posedge clk) begin
        if (rst) begin
            err       <= 1'b0;
            err_count <= 8'd0;
        end else if (mismatch) begin
            err       <= 1'b1;
            err_count <= sat_inc(err_count);
        end
    end
`endif
endmodule
